round_robin_arbiter: RTL and testbench

- N-requester round-robin arbiter with per-requester lock (grant hold).
- Produces a registered one-hot grant.
- Rotating priority gives fair service; the lock lets the current owner keep the resource across multiple cycles, e.g. for burst transfers on a shared bus or memory port.

---
 rtl/round_robin_arbiter_pkg.sv | 6 +
 rtl/round_robin_arbiter_rr_priority_picker.sv | 35 +++
 rtl/round_robin_arbiter.sv | 53 +++++
 tb/tb_round_robin_arbiter.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/round_robin_arbiter_pkg.sv
// rtl/round_robin_arbiter_pkg.sv - shared defaults for the round-robin arbiter
package round_robin_arbiter_pkg;

  localparam int RR_DEFAULT_N = 4;

endpackage

// File: rtl/round_robin_arbiter_rr_priority_picker.sv
// rtl/round_robin_arbiter_rr_priority_picker.sv - rotating-priority picker, first request above ptr wins
module rr_priority_picker
  import round_robin_arbiter_pkg::*;
#(
  parameter int N  = RR_DEFAULT_N,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  request,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic          valid,
  output logic [PW-1:0] pick_index
);

  logic [N-1:0] above_mask;
  logic [N-1:0] masked;
  logic [N-1:0] sel;

  // Bits strictly above ptr; empty when ptr is the top index (shift overflows to zero).
  assign above_mask = ~((N'(2) << ptr) - N'(1));
  assign masked     = request & above_mask;
  assign sel        = (|masked) ? masked : request;
  assign pick       = sel & (~sel + N'(1));
  assign valid      = |request;

  always_comb begin
    pick_index = '0;
    for (int i = 0; i < N; i++) begin
      if (pick[i]) begin
        pick_index = PW'(i);
      end
    end
  end

endmodule

// File: rtl/round_robin_arbiter.sv
// rtl/round_robin_arbiter.sv - N-way round-robin arbiter with registered one-hot grant and owner lock
module round_robin_arbiter
  import round_robin_arbiter_pkg::*;
#(
  parameter int N = RR_DEFAULT_N
) (
  input  logic         clock,
  input  logic         reset_b,
  input  logic [N-1:0] request,
  input  logic [N-1:0] lock,
  output logic [N-1:0] grant
);

  localparam int PW = $clog2(N);

  logic [N-1:0]  grant_q;
  logic [PW-1:0] ptr_q;
  logic [N-1:0]  pick;
  logic          pick_valid;
  logic [PW-1:0] pick_index;
  logic          hold;

  rr_priority_picker #(
    .N  (N),
    .PW (PW)
  ) u_picker (
    .request    (request),
    .ptr        (ptr_q),
    .pick       (pick),
    .valid      (pick_valid),
    .pick_index (pick_index)
  );

  // Only the current owner's lock bit matters; it holds even if its request dropped.
  assign hold = |(grant_q & lock);

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      grant_q <= '0;
      ptr_q   <= PW'(N - 1);
    end else if (hold) begin
      grant_q <= grant_q;
    end else if (pick_valid) begin
      grant_q <= pick;
      ptr_q   <= pick_index;
    end else begin
      grant_q <= '0;
    end
  end

  assign grant = grant_q;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// tb/tb_round_robin_arbiter.sv - randomized and directed checks of round_robin_arbiter against a behavioural model
module tb_round_robin_arbiter;

  localparam int N = 4;

  logic         clock;
  logic         reset_b;
  logic [N-1:0] request;
  logic [N-1:0] lock;
  logic [N-1:0] grant;

  int checks;
  int errors;
  int m_owner;
  int m_ptr;

  round_robin_arbiter #(.N(N)) dut (
    .clock   (clock),
    .reset_b (reset_b),
    .request (request),
    .lock    (lock),
    .grant   (grant)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] model_grant();
    logic [N-1:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] l);
    if (m_owner >= 0 && l[m_owner]) return;
    m_owner = -1;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (r[c]) begin
        m_owner = c;
        m_ptr   = c;
        break;
      end
    end
  endtask

  task automatic step(input logic [N-1:0] r, input logic [N-1:0] l, input string tag);
    request = r;
    lock    = l;
    @(posedge clock);
    #1;
    model_step(r, l);
    check_eq(tag, {28'b0, grant}, {28'b0, model_grant()});
  endtask

  task automatic step_exp(input logic [N-1:0] r, input logic [N-1:0] l,
                          input logic [N-1:0] exp, input string tag);
    step(r, l, tag);
    check_eq({tag, "_const"}, {28'b0, grant}, {28'b0, exp});
  endtask

  // Assert reset mid-cycle, confirm the immediate clear, release away from the edge.
  task automatic mid_reset(input string tag);
    #3;
    reset_b = 1'b0;
    #1;
    check_eq(tag, {28'b0, grant}, 32'h0);
    m_owner = -1;
    m_ptr   = N - 1;
    request = '0;
    lock    = '0;
    @(posedge clock);
    #1;
    reset_b = 1'b1;
  endtask

  initial begin
    logic [N-1:0] fair_seq [8];
    logic [N-1:0] r;
    logic [N-1:0] l;
    checks  = 0;
    errors  = 0;
    m_owner = -1;
    m_ptr   = N - 1;
    reset_b = 1'b0;
    request = '0;
    lock    = '0;
    @(posedge clock);
    @(posedge clock);
    #1;
    check_eq("reset_grant", {28'b0, grant}, 32'h0);
    reset_b = 1'b1;

    step_exp(4'b0010, 4'b0010, 4'b0010, "first_grant");
    step_exp(4'b0000, 4'b0010, 4'b0010, "hold_no_req");
    step_exp(4'b0101, 4'b0111, 4'b0010, "hold_others_req");
    step_exp(4'b0101, 4'b0101, 4'b0100, "release_rotate");
    step_exp(4'b0001, 4'b0101, 4'b0100, "hold_again");
    step_exp(4'b0001, 4'b0001, 4'b0001, "release_to_0");
    step_exp(4'b0000, 4'b0001, 4'b0001, "hold_idle");
    step_exp(4'b0000, 4'b0000, 4'b0000, "idle");

    mid_reset("reset_before_fair");
    fair_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int i = 0; i < 8; i++) begin
      step_exp(4'b1111, 4'b0000, fair_seq[i], "fairness");
    end

    mid_reset("reset_before_lock");
    step_exp(4'b1000, 4'b1000, 4'b1000, "lock_top");
    step_exp(4'b1000, 4'b1000, 4'b1000, "lock_top_hold");
    mid_reset("async_reset_mid_hold");
    step_exp(4'b1001, 4'b0000, 4'b0001, "after_reset_grant");

    step_exp(4'b0001, 4'b0000, 4'b0001, "regrant_same");

    for (int i = 0; i < 400; i++) begin
      r = N'($urandom);
      l = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      if ($urandom_range(0, 7) == 0) r = '0;
      step(r, l, "random");
      check_eq("onehot", {31'b0, $onehot0(grant)}, 32'h1);
      if (i == 200) mid_reset("random_reset");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
